// File: rtl/mru_snapshot_dump_if.sv
// Beat stream carrying a captured MRU snapshot, one entry per beat.
// The master side presents the beats and the slave side returns dump_ready_in.
interface mru_snapshot_dump_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] dump_data_out;
    logic [1:0]        dump_idx_out;
    logic              dump_last_out;
    logic              dump_valid_out;
    logic              dump_ready_in;

    modport master (
        output dump_data_out, dump_idx_out, dump_last_out, dump_valid_out,
        input  dump_ready_in
    );

    modport slave (
        input  dump_data_out, dump_idx_out, dump_last_out, dump_valid_out,
        output dump_ready_in
    );
endinterface

// File: rtl/mru_snapshot_dump.sv
// Captures the 4-entry MRU list on request and streams its valid entries out, entry 0 first.
// Optional MRU_DUMP_AUTO_EN: a change in the IDLE-state list versus the last capture starts a dump.
module mru_snapshot_dump #(
    parameter int DATA_W     = 8,
    parameter int ARRAY_SIZE = 4
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic [DATA_W-1:0] in_0,
    input  logic [DATA_W-1:0] in_1,
    input  logic [DATA_W-1:0] in_2,
    input  logic [DATA_W-1:0] in_3,
    input  logic              in_valid_0,
    input  logic              in_valid_1,
    input  logic              in_valid_2,
    input  logic              in_valid_3,
    input  logic              dump_req_in,
    mru_snapshot_dump_if.master dump,
    output logic              busy_out,
    output logic              done_out,
    output logic              req_dropped_out
);
    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [ARRAY_SIZE-1:0] ONE = ARRAY_SIZE'(1);

    state_t                               state_q, state_d;
    logic [ARRAY_SIZE-1:0][DATA_W-1:0]    in_data, snap_q, snap_d, src;
    logic [ARRAY_SIZE-1:0]                in_vld, svld_q, svld_d, pend_q, pend_d;
    logic [ARRAY_SIZE-1:0]                mask, rest;
    logic [1:0]                           nidx;
    logic [DATA_W-1:0]                    data_q, data_d;
    logic [1:0]                           idx_q, idx_d;
    logic                                 last_q, last_d;
    logic                                 valid_q, valid_d;
    logic                                 done_q, done_d;
    logic                                 drop_q, drop_d;
    logic                                 trig;

    assign in_data = {in_3, in_2, in_1, in_0};
    assign in_vld  = {in_valid_3, in_valid_2, in_valid_1, in_valid_0};

    function automatic logic [1:0] first_idx(input logic [ARRAY_SIZE-1:0] m);
        first_idx = 2'd0;
        for (int i = ARRAY_SIZE - 1; i >= 0; i--)
            if (m[i]) first_idx = 2'(i);
    endfunction

`ifdef MRU_DUMP_AUTO_EN
    // The snapshot registers double as the reference copy; stale data of invalid entries is ignored.
    logic auto_diff;
    always_comb begin
        auto_diff = (in_vld != svld_q);
        for (int i = 0; i < ARRAY_SIZE; i++)
            if (in_vld[i] && (in_data[i] != snap_q[i])) auto_diff = 1'b1;
    end
    assign trig = dump_req_in | auto_diff;
`else
    assign trig = dump_req_in;
`endif

    // First beat comes straight from the inputs being captured; later beats from the snapshot.
    assign mask = (state_q == IDLE) ? in_vld : pend_q;
    assign src  = (state_q == IDLE) ? in_data : snap_q;
    assign rest = mask & (mask - ONE);
    assign nidx = first_idx(mask);

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        svld_d  = svld_q;
        pend_d  = pend_q;
        data_d  = data_q;
        idx_d   = idx_q;
        last_d  = last_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        drop_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    snap_d = in_data;
                    svld_d = in_vld;
                    if (|in_vld) begin
                        state_d = SEND;
                        data_d  = src[nidx];
                        idx_d   = nidx;
                        last_d  = (rest == '0);
                        pend_d  = rest;
                        valid_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SEND: begin
                drop_d = dump_req_in;
                if (valid_q && dump.dump_ready_in) begin
                    if (last_q) begin
                        state_d = IDLE;
                        data_d  = '0;
                        idx_d   = 2'd0;
                        last_d  = 1'b0;
                        valid_d = 1'b0;
                        pend_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        data_d  = src[nidx];
                        idx_d   = nidx;
                        last_d  = (rest == '0);
                        pend_d  = rest;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= IDLE;
            snap_q  <= '0;
            svld_q  <= '0;
            pend_q  <= '0;
            data_q  <= '0;
            idx_q   <= 2'd0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            svld_q  <= svld_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

    assign dump.dump_data_out  = data_q;
    assign dump.dump_idx_out   = idx_q;
    assign dump.dump_last_out  = last_q;
    assign dump.dump_valid_out = valid_q;
    assign busy_out            = (state_q == SEND);
    assign done_out            = done_q;
    assign req_dropped_out     = drop_q;
endmodule

// File: tb/tb_mru_snapshot_dump.sv
// Randomized and directed bench for mru_snapshot_dump against a queue-based reference model.
module tb_mru_snapshot_dump;
    logic       clk_in = 1'b0;
    logic       reset_in;
    logic [7:0] in_d [4];
    logic [3:0] in_v;
    logic       req;
    logic       busy_out, done_out, req_dropped_out;
    int         n_chk = 0;
    int         n_bad = 0;

    mru_snapshot_dump_if #(.DATA_W(8)) dif ();

    mru_snapshot_dump #(.DATA_W(8), .ARRAY_SIZE(4)) dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .in_0            (in_d[0]),
        .in_1            (in_d[1]),
        .in_2            (in_d[2]),
        .in_3            (in_d[3]),
        .in_valid_0      (in_v[0]),
        .in_valid_1      (in_v[1]),
        .in_valid_2      (in_v[2]),
        .in_valid_3      (in_v[3]),
        .dump_req_in     (req),
        .dump            (dif.master),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .req_dropped_out (req_dropped_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] i;
    } beat_t;

    beat_t      q[$];
    bit         m_busy, m_done, m_drop;
    logic [7:0] c_d [4];
    logic [3:0] c_v;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_busy = 0; m_done = 0; m_drop = 0;
        c_v = '0;
        for (int i = 0; i < 4; i++) c_d[i] = '0;
    endtask

    // One clock edge of the block's behaviour, from the inputs as applied.
    task automatic model_step();
        bit trig;
        m_done = 0;
        m_drop = 0;
        if (m_busy) begin
            if (req) m_drop = 1;
            if (dif.dump_ready_in) begin
                void'(q.pop_front());
                if (q.size() == 0) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end else begin
            trig = req;
`ifdef MRU_DUMP_AUTO_EN
            if (c_v != in_v) trig = 1;
            for (int i = 0; i < 4; i++)
                if (in_v[i] && in_d[i] != c_d[i]) trig = 1;
`endif
            if (trig) begin
                for (int i = 0; i < 4; i++) begin
                    c_d[i] = in_d[i];
                    if (in_v[i]) q.push_back({in_d[i], 2'(i)});
                end
                c_v = in_v;
                if (q.size() == 0) m_done = 1;
                else m_busy = 1;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        model_step();
        @(negedge clk_in);
        chk("valid", dif.dump_valid_out, m_busy);
        chk("busy", busy_out, m_busy);
        chk("done", done_out, m_done);
        chk("dropped", req_dropped_out, m_drop);
        if (m_busy && q.size() > 0) begin
            chk("data", dif.dump_data_out, q[0].d);
            chk("idx", dif.dump_idx_out, q[0].i);
            chk("last", dif.dump_last_out, q.size() == 1);
        end
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_valid"}, dif.dump_valid_out, 0);
        chk({tag, "_data"}, dif.dump_data_out, 0);
        chk({tag, "_idx"}, dif.dump_idx_out, 0);
        chk({tag, "_last"}, dif.dump_last_out, 0);
        chk({tag, "_busy"}, busy_out, 0);
        chk({tag, "_done"}, done_out, 0);
        chk({tag, "_dropped"}, req_dropped_out, 0);
    endtask

    task automatic set_in(input logic [7:0] a, b, c, d, input logic [3:0] v);
        in_d[0] = a; in_d[1] = b; in_d[2] = c; in_d[3] = d;
        in_v = v;
    endtask

    initial begin
        reset_in = 1'b1;
        req = 1'b0;
        dif.dump_ready_in = 1'b0;
        set_in(8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
        model_reset();
        repeat (2) @(negedge clk_in);
        check_cleared("rst");
        reset_in = 1'b0;

        // All valid, ready held high: four back-to-back beats then done.
        set_in(8'hA1, 8'hB2, 8'hC3, 8'hD4, 4'hF);
        dif.dump_ready_in = 1'b1;
        req = 1'b1; cyc(); req = 1'b0;
        repeat (5) cyc();

        // Two valid entries with ready pattern 1,0,0,1.
        set_in(8'h11, 8'h22, 8'h33, 8'h44, 4'b0011);
        req = 1'b1; cyc(); req = 1'b0;
        dif.dump_ready_in = 1'b1; cyc();
        dif.dump_ready_in = 1'b0; cyc(); cyc();
        dif.dump_ready_in = 1'b1; cyc(); cyc();

        // Nothing valid: immediate done, no beat.
        set_in(8'h55, 8'h66, 8'h77, 8'h88, 4'h0);
        req = 1'b1; cyc(); req = 1'b0;
        repeat (2) cyc();

        // Request during SEND and inputs overwritten after capture.
        set_in(8'h01, 8'h02, 8'h03, 8'h04, 4'hF);
        req = 1'b1; cyc(); req = 1'b0;
        set_in(8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'hF);
        cyc();
        req = 1'b1; cyc(); req = 1'b0;
        cyc();
        req = 1'b1; cyc(); req = 1'b0;
        repeat (6) cyc();

        // Reset in the middle of a dump clears outputs immediately.
        set_in(8'h9A, 8'hBC, 8'hDE, 8'hF0, 4'b1101);
        dif.dump_ready_in = 1'b0;
        req = 1'b1; cyc(); req = 1'b0;
        cyc();
        #2 reset_in = 1'b1;
        #1 check_cleared("midrst");
        model_reset();
        @(negedge clk_in);
        reset_in = 1'b0;
        dif.dump_ready_in = 1'b1;
        repeat (3) cyc();

`ifdef MRU_DUMP_AUTO_EN
        // A change in entry 0 alone starts a dump; stable inputs afterwards do not.
        set_in(8'h10, 8'h00, 8'h00, 8'h00, 4'b0001);
        repeat (6) cyc();
        in_d[0] = 8'h20;
        repeat (8) cyc();
`endif

        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                for (int i = 0; i < 4; i++) in_d[i] = 8'($urandom);
                in_v = 4'($urandom);
            end
            req = ($urandom_range(0, 3) == 0);
            dif.dump_ready_in = ($urandom_range(0, 9) < 7);
            cyc();
        end
        req = 1'b0;
        dif.dump_ready_in = 1'b1;
        repeat (8) cyc();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
